sar_conv_sequencer: RTL and testbench

//   Host-side initiator for the sar_logic converter: issues cnvst pulses (single-shot or periodic),

---
 rtl/sar_pkg.sv | 25 ++
 rtl/sar_result_fifo.sv | 56 +++++
 rtl/sar_conv_sequencer.sv | 154 +++++++++++++++
 tb/tb_sar_conv_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR converter sequencer and the sar_logic benches:
// default result width, sequencer FSM encodings and counter sizing.
package sar_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int PERIOD_W   = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PULSE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_HOLDOFF = 3'd4
   } seq_state_e;

   // One shared counter covers the cnvst pulse, the eoc timeout and the holdoff period.
   function automatic int seq_cnt_width(input int timeout, input int cnvst_len);
      int w;
      w = PERIOD_W;
      if ($clog2(timeout) > w) w = $clog2(timeout);
      if ($clog2(cnvst_len) > w) w = $clog2(cnvst_len);
      return w;
   endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// Small first-word-fall-through result FIFO; a push into a full FIFO is taken
// only when a pop happens on the same edge, otherwise it is dropped.
module sar_result_fifo
   import sar_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; head is masked to 0 while empty, so stale words never escape.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Host-side conversion sequencer for sar_logic: pulses cnvst (single-shot or periodic),
// waits for the eoc rising edge, queues results and flags timeout/overrun.
module sar_conv_sequencer
   import sar_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int CNVST_LEN  = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                cont_en,
   input  logic [PERIOD_W-1:0] period,
   input  logic                clr_err,
   output logic                cnvst,
   input  logic                eoc,
   input  logic [DATA_W-1:0]   sar,
   input  logic                rd_en,
   output logic [DATA_W-1:0]   rd_data,
   output logic                empty,
   output logic                full,
   output logic                busy,
   output logic                overrun,
   output logic                timeout_err
);

   localparam int               CNT_W      = seq_cnt_width(TIMEOUT, CNVST_LEN);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(CNVST_LEN - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, hold_last;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic              cnvst_q, cnvst_d, busy_q, busy_d;
   logic              eoc_prev_q, eoc_prev_d;
   logic              overrun_q, overrun_d, timeout_q, timeout_d;
   logic              eoc_rise, push, ovr_set, tmo_set;

   assign eoc_rise  = eoc & ~eoc_prev_q;
   // A programmed period of 0 behaves exactly like 1.
   assign hold_last = CNT_W'((period == '0) ? '0 : period - PERIOD_W'(1));

   assign cnvst       = cnvst_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_d      = cap_q;
      cnvst_d    = 1'b0;
      eoc_prev_d = eoc;
      push       = 1'b0;
      ovr_set    = 1'b0;
      tmo_set    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start || cont_en) begin
               state_d = S_PULSE;
               cnt_d   = '0;
               cnvst_d = 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               cnvst_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (eoc_rise) begin
               state_d = S_CAPTURE;
               cap_d   = sar;
            end else if (cnt_q == TMO_LAST) begin
               tmo_set = 1'b1;
               state_d = cont_en ? S_HOLDOFF : S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            push    = 1'b1;
            ovr_set = full & ~rd_en;
            state_d = cont_en ? S_HOLDOFF : S_IDLE;
            cnt_d   = '0;
         end
         S_HOLDOFF: begin
            if (cnt_q >= hold_last) begin
               cnt_d = '0;
               if (cont_en) begin
                  state_d = S_PULSE;
                  cnvst_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE);
      overrun_d = ovr_set | (overrun_q & ~clr_err);
      timeout_d = tmo_set | (timeout_q & ~clr_err);
   end

   // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cap_q      <= '0;
         cnvst_q    <= 1'b0;
         busy_q     <= 1'b0;
         eoc_prev_q <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         cnvst_q    <= cnvst_d;
         busy_q     <= busy_d;
         eoc_prev_q <= eoc_prev_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
      end
   end

   sar_result_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (cap_q),
      .pop       (rd_en),
      .head      (rd_data),
      .empty     (empty),
      .full      (full)
   );

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural sar_logic responder
// that raises eoc a programmable number of cycles after cnvst falls.
module tb_sar_conv_sequencer;

   logic        clk, rst, start, cont_en, clr_err, rd_en;
   logic [15:0] period;
   logic        cnvst, eoc, empty, full, busy, overrun, timeout_err;
   logic [7:0]  sar, rd_data;

   logic        resp_en;
   int          resp_delay;
   logic [7:0]  resp_data [8];
   logic [2:0]  resp_cnt;
   logic        resp_eoc;
   logic [7:0]  resp_sar;
   logic        man_eoc;
   logic [7:0]  man_sar;
   int          cnvst_rises;
   int          n_checks, n_fail;

   assign eoc = resp_eoc | man_eoc;
   assign sar = resp_eoc ? resp_sar : man_sar;

   sar_conv_sequencer #(
      .DATA_W(8), .FIFO_DEPTH(4), .CNVST_LEN(2), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cont_en(cont_en), .period(period),
      .clr_err(clr_err), .cnvst(cnvst), .eoc(eoc), .sar(sar), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .full(full), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder: eoc rises resp_delay cycles after cnvst falls, held high for 2 cycles.
   initial begin : responder
      int   cd, hold;
      logic prev;
      resp_eoc = 1'b0; resp_sar = 8'h00; resp_cnt = 3'd0;
      cd = 0; hold = 0; prev = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (hold > 0) begin
            hold--;
            if (hold == 0) resp_eoc = 1'b0;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               resp_eoc = 1'b1;
               resp_sar = resp_data[resp_cnt];
               resp_cnt = resp_cnt + 3'd1;
               hold     = 2;
            end
         end
         if (resp_en && prev && !cnvst) cd = resp_delay;
         prev = cnvst;
      end
   end

   initial begin : cnvst_mon
      logic prev;
      prev = 1'b0; cnvst_rises = 0;
      forever begin
         @(posedge clk); #3;
         if (cnvst && !prev) cnvst_rises++;
         prev = cnvst;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion within 500000 ns");
      $fatal(1, "simulation time limit reached");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input int max_cycles, input string name);
      int n;
      n = 0;
      tick();
      while (busy !== 1'b0 && n < max_cycles) begin tick(); n++; end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: busy=%b after %0d cycles, expected 0", name, busy, max_cycles);
      end
   endtask

   task automatic pop_expect(input logic [7:0] exp, input string name);
      n_checks++;
      if (rd_data !== exp) begin
         n_fail++;
         $display("FAIL %s: rd_data=%h expected %h", name, rd_data, exp);
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
   endtask

   task automatic do_single(input logic [7:0] val, input string name);
      resp_data[resp_cnt] = val;
      start = 1'b1; tick(); start = 1'b0;
      wait_idle(200, name);
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_checks++;
      if ({cnvst, busy, empty, full, overrun, timeout_err, rd_data} !== {6'b001000, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_state: cnvst/busy/empty/full/ovr/tmo=%b%b%b%b%b%b rd_data=%h expected 001000 00",
                  cnvst, busy, empty, full, overrun, timeout_err, rd_data);
      end
      rst = 1'b1; tick();
      n_checks++;
      if ({busy, empty} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_release: busy/empty=%b%b expected 01", busy, empty);
      end
   endtask

   task automatic test_single();
      resp_en = 1'b1; resp_delay = 10;
      resp_data[resp_cnt] = 8'hA5;
      start = 1'b1; tick(); start = 1'b0;
      n_checks++;
      if ({cnvst, busy} !== 2'b11) begin
         n_fail++; $display("FAIL single_cnvst_c1: cnvst/busy=%b%b expected 11", cnvst, busy);
      end
      tick();
      n_checks++;
      if (cnvst !== 1'b1) begin
         n_fail++; $display("FAIL single_cnvst_c2: cnvst=%b expected 1", cnvst);
      end
      tick();
      n_checks++;
      if ({cnvst, busy} !== 2'b01) begin
         n_fail++; $display("FAIL single_cnvst_fall: cnvst/busy=%b%b expected 01", cnvst, busy);
      end
      repeat (11) tick();
      n_checks++;
      if ({empty, busy} !== 2'b11) begin
         n_fail++; $display("FAIL single_capture_cycle: empty/busy=%b%b expected 11", empty, busy);
      end
      tick();
      n_checks++;
      if ({empty, busy, rd_data} !== {2'b00, 8'hA5}) begin
         n_fail++;
         $display("FAIL single_result: empty/busy=%b%b rd_data=%h expected 00 a5", empty, busy, rd_data);
      end
      pop_expect(8'hA5, "single_pop");
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL single_empty_after_pop: empty=%b expected 1", empty);
      end
   endtask

   task automatic test_continuous();
      int n;
      resp_en = 1'b1; resp_delay = 3; period = 16'd5;
      for (int i = 0; i < 5; i++) resp_data[resp_cnt + 3'(i)] = 8'(i + 1);
      cont_en = 1'b1;
      n = 0;
      while (overrun !== 1'b1 && n < 300) begin tick(); n++; end
      cont_en = 1'b0;
      n_checks++;
      if (overrun !== 1'b1) begin
         n_fail++; $display("FAIL cont_overrun: overrun=%b after 300 cycles, expected 1", overrun);
      end
      wait_idle(100, "cont_idle");
      n_checks++;
      if ({full, overrun} !== 2'b11) begin
         n_fail++; $display("FAIL cont_full: full/overrun=%b%b expected 11", full, overrun);
      end
      for (int i = 0; i < 4; i++) pop_expect(8'(i + 1), "cont_pop");
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL cont_drained: empty=%b expected 1", empty);
      end
   endtask

   task automatic test_timeout();
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      n_checks++;
      if (overrun !== 1'b0) begin
         n_fail++; $display("FAIL clr_overrun: overrun=%b expected 0", overrun);
      end
      resp_en = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (2) tick();
      repeat (63) tick();
      n_checks++;
      if ({timeout_err, busy} !== 2'b01) begin
         n_fail++; $display("FAIL tmo_last_wait: timeout_err/busy=%b%b expected 01", timeout_err, busy);
      end
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      n_checks++;
      if ({timeout_err, busy, empty} !== 3'b101) begin
         n_fail++;
         $display("FAIL tmo_set_wins: timeout_err/busy/empty=%b%b%b expected 101", timeout_err, busy, empty);
      end
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL tmo_clear: timeout_err=%b expected 0", timeout_err);
      end
   endtask

   task automatic test_full_pop();
      int n;
      resp_en = 1'b1; resp_delay = 4;
      do_single(8'h10, "fill_1");
      do_single(8'h20, "fill_2");
      do_single(8'h30, "fill_3");
      do_single(8'h40, "fill_4");
      n_checks++;
      if ({full, overrun} !== 2'b10) begin
         n_fail++; $display("FAIL fill_full: full/overrun=%b%b expected 10", full, overrun);
      end
      resp_data[resp_cnt] = 8'h3C;
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (eoc !== 1'b1 && n < 50) begin tick(); n++; end
      n_checks++;
      if (eoc !== 1'b1) begin
         n_fail++; $display("FAIL fullpop_eoc: eoc=%b after 50 cycles, expected 1", eoc);
      end
      pop_expect(8'h10, "fullpop_head");
      n_checks++;
      if ({full, overrun} !== 2'b10) begin
         n_fail++; $display("FAIL fullpop_no_overrun: full/overrun=%b%b expected 10", full, overrun);
      end
      wait_idle(20, "fullpop_idle");
      pop_expect(8'h20, "fullpop_pop_2");
      pop_expect(8'h30, "fullpop_pop_3");
      pop_expect(8'h40, "fullpop_pop_4");
      pop_expect(8'h3C, "fullpop_tail");
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL fullpop_drained: empty=%b expected 1", empty);
      end
   endtask

   task automatic test_reset_mid_op();
      resp_en = 1'b1; resp_delay = 4;
      do_single(8'h77, "pre_reset_single");
      n_checks++;
      if (empty !== 1'b0) begin
         n_fail++; $display("FAIL pre_reset_data: empty=%b expected 0", empty);
      end
      resp_en = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      n_checks++;
      if (cnvst !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_pulse: cnvst=%b expected 1", cnvst);
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({cnvst, busy, empty, rd_data} !== {3'b001, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_reset_state: cnvst/busy/empty=%b%b%b rd_data=%h expected 001 00",
                  cnvst, busy, empty, rd_data);
      end
      #2 rst = 1'b1;
      repeat (3) tick();
      resp_en = 1'b1;
      do_single(8'h5A, "post_reset_single");
      n_checks++;
      if ({empty, rd_data} !== {1'b0, 8'h5A}) begin
         n_fail++; $display("FAIL post_reset_result: empty=%b rd_data=%h expected 0 5a", empty, rd_data);
      end
      pop_expect(8'h5A, "post_reset_pop");
   endtask

   task automatic test_busy_start();
      int base;
      resp_en = 1'b0; man_sar = 8'hC3; man_eoc = 1'b1;
      tick();
      base = cnvst_rises;
      start = 1'b1; tick();
      tick(); start = 1'b0;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (4) tick();
      n_checks++;
      if ({empty, busy, cnvst} !== 3'b110) begin
         n_fail++;
         $display("FAIL eoc_high_entry: empty/busy/cnvst=%b%b%b expected 110", empty, busy, cnvst);
      end
      man_eoc = 1'b0; tick();
      man_eoc = 1'b1; tick();
      n_checks++;
      if ({empty, busy} !== 2'b11) begin
         n_fail++; $display("FAIL late_edge_capture: empty/busy=%b%b expected 11", empty, busy);
      end
      tick();
      n_checks++;
      if ({empty, busy, rd_data} !== {2'b00, 8'hC3}) begin
         n_fail++;
         $display("FAIL late_edge_result: empty/busy=%b%b rd_data=%h expected 00 c3", empty, busy, rd_data);
      end
      man_eoc = 1'b0;
      pop_expect(8'hC3, "late_edge_pop");
      repeat (5) tick();
      n_checks++;
      if (cnvst_rises - base !== 1 || busy !== 1'b0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL start_ignored: cnvst rises=%0d busy=%b empty=%b expected 1 0 1",
                  cnvst_rises - base, busy, empty);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cont_en = 1'b0; period = 16'd5; clr_err = 1'b0; rd_en = 1'b0;
      resp_en = 1'b0; resp_delay = 10; man_eoc = 1'b0; man_sar = 8'h00;
      n_checks = 0; n_fail = 0;
      for (int i = 0; i < 8; i++) resp_data[i] = 8'h00;
      test_reset();
      test_single();
      test_continuous();
      test_timeout();
      test_full_pop();
      test_reset_mid_op();
      test_busy_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
